// File: rtl/instr_enc_pkg.sv
// Shared definitions for the LEGv8 instruction encoder: op select enum,
// opcode constants and instruction memory geometry.
package instr_enc_pkg;

    typedef enum logic [2:0] {
        OP_ADD  = 3'd0,
        OP_SUB  = 3'd1,
        OP_AND  = 3'd2,
        OP_ORR  = 3'd3,
        OP_LDUR = 3'd4,
        OP_STUR = 3'd5,
        OP_CBZ  = 3'd6,
        OP_RSVD = 3'd7
    } instrOp_e;

    localparam logic [10:0] OPC_ADD  = 11'b10001011000;
    localparam logic [10:0] OPC_SUB  = 11'b11001011000;
    localparam logic [10:0] OPC_AND  = 11'b10001010000;
    localparam logic [10:0] OPC_ORR  = 11'b10101010000;
    localparam logic [10:0] OPC_LDUR = 11'b11111000010;
    localparam logic [10:0] OPC_STUR = 11'b11111000000;
    localparam logic [7:0]  OPC_CBZ  = 8'b10110100;

    localparam int IMEM_DEPTH = 64;
    localparam int ADDR_W     = $clog2(IMEM_DEPTH);

    function automatic logic isDType(input instrOp_e op);
        return (op == OP_LDUR) || (op == OP_STUR);
    endfunction

endpackage

// File: rtl/instr_pack.sv
// Combinational field packer: turns an op select plus register/immediate
// fields into a 32-bit LEGv8 word and flags the reserved op.
module instr_pack
    import instr_enc_pkg::*;
(
    input  instrOp_e    op,
    input  logic [4:0]  rd,
    input  logic [4:0]  rn,
    input  logic [4:0]  rm,
    input  logic [18:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    always_comb begin
        word    = 32'd0;
        illegal = 1'b0;
        unique case (op)
            OP_ADD:  word = {OPC_ADD,  rm, 6'b000000, rn, rd};
            OP_SUB:  word = {OPC_SUB,  rm, 6'b000000, rn, rd};
            OP_AND:  word = {OPC_AND,  rm, 6'b000000, rn, rd};
            OP_ORR:  word = {OPC_ORR,  rm, 6'b000000, rn, rd};
            // D-type keeps only the low nine immediate bits; range policing is the caller's job
            OP_LDUR: word = {OPC_LDUR, imm[8:0], 2'b00, rn, rd};
            OP_STUR: word = {OPC_STUR, imm[8:0], 2'b00, rn, rd};
            OP_CBZ:  word = {OPC_CBZ,  imm, rd};
            OP_RSVD: illegal = 1'b1;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder.sv
// Streams encoded instruction beats into a 64-entry instruction memory write port.
// Optional macro ENC_RANGE_CHECK_EN rejects D-type immediates that do not fit 9 signed bits.
module instr_encoder
    import instr_enc_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [2:0]        in_op,
    input  logic [4:0]        in_rd,
    input  logic [4:0]        in_rn,
    input  logic [4:0]        in_rm,
    input  logic [18:0]       in_imm,
    input  logic              in_last,
    output logic              wr_en,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [31:0]       wr_data,
    output logic              done,
    output logic              err_illegal,
    output logic              err_range
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        DONE = 2'd2
    } encState_e;

    encState_e      state, nextState;
    instrOp_e       beatOp;
    logic [31:0]    packedWord;
    logic           beatIllegal;
    logic           rangeBad;
    logic           accept;
    logic           doWrite;
    logic           lastSlot;
    logic [ADDR_W:0] writeCount;
    logic           errIllegal;
    logic           errRange;

    assign beatOp = instrOp_e'(in_op);

    instr_pack packer (
        .op      (beatOp),
        .rd      (in_rd),
        .rn      (in_rn),
        .rm      (in_rm),
        .imm     (in_imm),
        .word    (packedWord),
        .illegal (beatIllegal)
    );

`ifdef ENC_RANGE_CHECK_EN
    // A 9-bit signed offset sign-extends cleanly only if bits 18..8 all agree
    assign rangeBad = isDType(beatOp) && !((&in_imm[18:8]) || !(|in_imm[18:8]));
`else
    assign rangeBad = 1'b0;
`endif

    assign in_ready    = (state == LOAD) && !start;
    assign accept      = in_valid && in_ready;
    assign doWrite     = accept && !beatIllegal && !rangeBad;
    assign lastSlot    = (writeCount == (ADDR_W + 1)'(IMEM_DEPTH - 1));
    assign done        = (state == DONE);
    assign err_illegal = errIllegal;
    assign err_range   = errRange;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= nextState;
        end
    end

    always_comb begin
        nextState = state;
        unique case (state)
            IDLE: if (start) nextState = LOAD;
            LOAD: begin
                if (start) begin
                    nextState = LOAD;
                end else if (accept && (in_last || (doWrite && lastSlot))) begin
                    nextState = DONE;
                end
            end
            DONE: if (start) nextState = LOAD;
            default: nextState = IDLE;
        endcase
    end

    // Rejected beats still consume a slot in the stream but never touch the address
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= 32'd0;
            writeCount <= '0;
            errIllegal <= 1'b0;
            errRange   <= 1'b0;
        end else begin
            wr_en <= 1'b0;
            if (start) begin
                wr_addr    <= '0;
                writeCount <= '0;
                errIllegal <= 1'b0;
                errRange   <= 1'b0;
            end else if (accept) begin
                if (beatIllegal) begin
                    errIllegal <= 1'b1;
                end else if (rangeBad) begin
                    errRange <= 1'b1;
                end else begin
                    wr_en      <= 1'b1;
                    wr_addr    <= writeCount[ADDR_W-1:0];
                    wr_data    <= packedWord;
                    writeCount <= writeCount + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_instr_encoder.sv
// Self-checking bench for instr_encoder: directed scenarios plus randomized
// beat streams compared against an arithmetic reference model.
module tb_instr_encoder;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [2:0]  in_op = '0;
    logic [4:0]  in_rd = '0;
    logic [4:0]  in_rn = '0;
    logic [4:0]  in_rm = '0;
    logic [18:0] in_imm = '0;
    logic        in_last = 1'b0;
    logic        wr_en;
    logic [5:0]  wr_addr;
    logic [31:0] wr_data;
    logic        done;
    logic        err_illegal;
    logic        err_range;

    int checkCount = 0;
    int passCount  = 0;

    // Reference model state
    bit modelLoad = 0;
    bit modelDone = 0;
    int nextAddr  = 0;
    bit modelErrIll = 0;
    bit modelErrRng = 0;
    int writeTally = 0;

    instr_encoder dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_op       (in_op),
        .in_rd       (in_rd),
        .in_rn       (in_rn),
        .in_rm       (in_rm),
        .in_imm      (in_imm),
        .in_last     (in_last),
        .wr_en       (wr_en),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .done        (done),
        .err_illegal (err_illegal),
        .err_range   (err_range)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checkCount++;
        if (observed === expected) begin
            passCount++;
        end else begin
            $display("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
        end
    endtask

    // Encoding from the instruction-format tables, using plain arithmetic
    function automatic longint encodeRef(input int op, input int rd, input int rn, input int rm, input int imm);
        longint opc;
        case (op)
            0: opc = 'h458;
            1: opc = 'h658;
            2: opc = 'h450;
            3: opc = 'h550;
            4: opc = 'h7C2;
            5: opc = 'h7C0;
            default: opc = 0;
        endcase
        if (op <= 3) return opc * (2**21) + rm * (2**16) + rn * 32 + rd;
        if (op <= 5) return opc * (2**21) + (imm % 512) * (2**12) + rn * 32 + rd;
        return longint'('hB4) * (2**24) + longint'(imm) * 32 + rd;
    endfunction

    function automatic bit outOfRange(input int op, input logic [18:0] imm);
        int sval;
        sval = int'($signed(imm));
`ifdef ENC_RANGE_CHECK_EN
        return (op == 4 || op == 5) && (sval < -256 || sval > 255);
`else
        return 1'b0;
`endif
    endfunction

    task automatic modelReset();
        modelLoad   = 0;
        modelDone   = 0;
        nextAddr    = 0;
        modelErrIll = 0;
        modelErrRng = 0;
    endtask

    // Drive one cycle of inputs, check in_ready before the edge and all outputs after it
    task automatic applyStimulus(input bit st, input bit v, input int op, input int rd, input int rn,
                                 input int rm, input logic [18:0] imm, input bit last);
        bit expWr;
        int expAddr;
        longint expData;
        bit expReady;
        start    = st;
        in_valid = v;
        in_op    = 3'(op);
        in_rd    = 5'(rd);
        in_rn    = 5'(rn);
        in_rm    = 5'(rm);
        in_imm   = imm;
        in_last  = last;
        expReady = modelLoad && !st;
        #1;
        checkOutput("in_ready", {31'd0, in_ready}, {31'd0, expReady});
        expWr = 0;
        expAddr = 0;
        expData = 0;
        if (st) begin
            modelLoad   = 1;
            modelDone   = 0;
            nextAddr    = 0;
            modelErrIll = 0;
            modelErrRng = 0;
        end else if (expReady && v) begin
            if (op == 7) begin
                modelErrIll = 1;
            end else if (outOfRange(op, imm)) begin
                modelErrRng = 1;
            end else begin
                expWr   = 1;
                expAddr = nextAddr;
                expData = encodeRef(op, rd, rn, rm, int'(imm));
                nextAddr++;
            end
            if (last || nextAddr == 64) begin
                modelLoad = 0;
                modelDone = 1;
            end
        end
        @(posedge clk);
        #1;
        checkOutput("wr_en", {31'd0, wr_en}, {31'd0, expWr});
        if (expWr) begin
            writeTally++;
            checkOutput("wr_addr", {26'd0, wr_addr}, 32'(expAddr));
            checkOutput("wr_data", wr_data, expData[31:0]);
        end
        checkOutput("done", {31'd0, done}, {31'd0, modelDone});
        checkOutput("err_illegal", {31'd0, err_illegal}, {31'd0, modelErrIll});
        checkOutput("err_range", {31'd0, err_range}, {31'd0, modelErrRng});
    endtask

    task automatic idleCycle();
        applyStimulus(0, 0, 0, 0, 0, 0, 19'd0, 0);
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, "_wr_en"}, {31'd0, wr_en}, 32'd0);
        checkOutput({tag, "_wr_addr"}, {26'd0, wr_addr}, 32'd0);
        checkOutput({tag, "_wr_data"}, wr_data, 32'd0);
        checkOutput({tag, "_in_ready"}, {31'd0, in_ready}, 32'd0);
        checkOutput({tag, "_done"}, {31'd0, done}, 32'd0);
        checkOutput({tag, "_err_illegal"}, {31'd0, err_illegal}, 32'd0);
        checkOutput({tag, "_err_range"}, {31'd0, err_range}, 32'd0);
    endtask

    initial begin
        // Power-on reset
        #12;
        checkAllZero("reset");
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;

        // Single ADD
        applyStimulus(1, 0, 0, 0, 0, 0, 19'd0, 0);
        applyStimulus(0, 1, 0, 9, 10, 11, 19'd0, 0);
        checkOutput("add_word", wr_data, 32'h8B0B0149);
        checkOutput("add_addr", {26'd0, wr_addr}, 32'd0);
        idleCycle();

        // LDUR then CBZ with in_last
        applyStimulus(1, 0, 0, 0, 0, 0, 19'd0, 0);
        applyStimulus(0, 1, 4, 1, 2, 0, 19'd8, 0);
        checkOutput("ldur_word", wr_data, 32'hF8408041);
        applyStimulus(0, 1, 6, 3, 0, 0, 19'h7FFFE, 1);
        checkOutput("cbz_word", wr_data, 32'hB4FFFFC3);
        checkOutput("cbz_addr", {26'd0, wr_addr}, 32'd1);
        checkOutput("cbz_done", {31'd0, done}, 32'd1);
        checkOutput("cbz_ready", {31'd0, in_ready}, 32'd0);

        // 70 back-to-back beats: only 64 writes, no wrap
        applyStimulus(1, 0, 0, 0, 0, 0, 19'd0, 0);
        writeTally = 0;
        for (int i = 0; i < 70; i++) begin
            applyStimulus(0, 1, i % 4, $urandom_range(31), $urandom_range(31), $urandom_range(31), 19'd0, 0);
            if (i == 63) begin
                checkOutput("full_addr63", {26'd0, wr_addr}, 32'd63);
                checkOutput("full_done", {31'd0, done}, 32'd1);
            end
        end
        checkOutput("full_write_count", 32'(writeTally), 32'd64);

        // Reserved op between two ADDs
        applyStimulus(1, 0, 0, 0, 0, 0, 19'd0, 0);
        applyStimulus(0, 1, 0, 1, 2, 3, 19'd0, 0);
        applyStimulus(0, 1, 7, 4, 5, 6, 19'd0, 0);
        checkOutput("illegal_flag", {31'd0, err_illegal}, 32'd1);
        applyStimulus(0, 1, 0, 7, 8, 9, 19'd0, 0);
        checkOutput("illegal_second_addr", {26'd0, wr_addr}, 32'd1);

        // LDUR with an immediate beyond 9 signed bits
        applyStimulus(1, 0, 0, 0, 0, 0, 19'd0, 0);
        applyStimulus(0, 1, 4, 1, 2, 0, 19'd300, 0);
`ifdef ENC_RANGE_CHECK_EN
        checkOutput("range_flag", {31'd0, err_range}, 32'd1);
        checkOutput("range_no_write", {31'd0, wr_en}, 32'd0);
`else
        checkOutput("trunc_word", wr_data, 32'hF852C041);
        checkOutput("range_tied", {31'd0, err_range}, 32'd0);
`endif

        // Asynchronous reset mid-session with a valid beat pending
        applyStimulus(1, 0, 0, 0, 0, 0, 19'd0, 0);
        applyStimulus(0, 1, 1, 5, 6, 7, 19'd0, 0);
        in_valid = 1'b1;
        #2;
        reset = 1'b0;
        #1;
        checkAllZero("midreset");
        modelReset();
        @(negedge clk);
        reset = 1'b1;
        @(posedge clk);
        #1;
        applyStimulus(1, 0, 0, 0, 0, 0, 19'd0, 0);
        applyStimulus(0, 1, 2, 12, 13, 14, 19'd0, 0);
        checkOutput("resume_addr", {26'd0, wr_addr}, 32'd0);

        // Randomized sessions
        for (int s = 0; s < 6; s++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 19'd0, 0);
            for (int i = 0; i < 40; i++) begin
                applyStimulus($urandom_range(49) == 0, $urandom_range(3) != 0, $urandom_range(7),
                              $urandom_range(31), $urandom_range(31), $urandom_range(31),
                              ($urandom_range(1) == 1) ? 19'($urandom) : 19'($signed($urandom_range(511)) - 256),
                              $urandom_range(29) == 0);
            end
        end

        $display("[TB] %0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 SHALL have port clk  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous active-low reset.
REQ-004 SHALL have port start  input  1  pulse: clear address/errors, begin load session.
REQ-005 SHALL have port in_valid  input  1  instruction beat valid.
REQ-006 SHALL have port in_ready  output  1  beat accepted when in_valid & in_ready.
REQ-007 SHALL have port in_op  input  3  op select: 0 ADD, 1 SUB, 2 AND, 3 ORR, 4 LDUR, 5 STUR, 6 CBZ, 7 reserved.
REQ-008 SHALL have ports in_rd, in_rn, in_rm  input  5 each  Rd/Rt, Rn, Rm register indices.
REQ-009 SHALL have port in_imm  input  19  signed immediate (D-type address / CB offset).
REQ-010 SHALL have port in_last  input  1  marks final beat of session.
REQ-011 SHALL have ports wr_en  output  1, wr_addr  output  6, wr_data  output  32  imem write port.
REQ-012 SHALL have ports done  output  1, err_illegal  output  1, err_range  output  1  status.

Function
REQ-013 SHALL encode LEGv8 words: R-type {opcode[10:0], Rm, shamt=000000, Rn, Rd} with ADD 10001011000, SUB 11001011000, AND 10001010000, ORR 10101010000.
REQ-014 SHALL encode D-type {opcode, imm[8:0], 00, Rn, Rt} with LDUR 11111000010, STUR 11111000000.
REQ-015 SHALL encode CB-type {10110100, imm[18:0], Rt}; in_rn/in_rm ignored.
REQ-016 SHALL implement FSM IDLE -> LOAD on start; LOAD -> DONE on accepted in_last beat or 64th accepted write; DONE -> LOAD on start; start in LOAD restarts LOAD.
REQ-017 SHALL drive in_ready = (state==LOAD) & !start; start wins over simultaneous in_valid (beat not accepted).
REQ-018 SHALL register outputs: beat accepted in cycle N -> wr_en=1 with wr_addr/wr_data valid in cycle N+1 only; wr_en one cycle per beat.
REQ-019 SHALL start wr_addr at 0 per session, increment after each performed write, no wrap: 64 writes -> DONE, in_ready=0.
REQ-020 SHALL consume op 7 beats without a write, setting sticky err_illegal; address not incremented.
REQ-021 SHALL assert done (level) in DONE; cleared on start.
REQ-022 SHALL consume an in_last beat that is illegal/out-of-range without writing, still entering DONE.

Reset
REQ-023 SHALL on reset assertion immediately force state IDLE, wr_en=0, wr_addr=0, wr_data=0, in_ready=0, done=0, err_illegal=0, err_range=0, including mid-session; in-flight write discarded.

Configuration
REQ-024 SHALL, with ENC_RANGE_CHECK_EN defined, flag LDUR/STUR beats whose in_imm[18:8] is not all-equal: no write, address held, sticky err_range=1 (cleared by start).
REQ-025 SHALL, without ENC_RANGE_CHECK_EN, silently truncate D-type immediates to imm[8:0] and tie err_range to 0.

Structure
REQ-026 SHALL place op enum, 11-bit/8-bit opcode constants and IMEM_DEPTH=64 in shared package instr_enc_pkg.
REQ-027 SHALL implement field packing as combinational sub-module instr_pack (op, rd, rn, rm, imm -> 32-bit word, illegal flag).

Verification
REQ-028 SHALL test: start, beat ADD rd=9 rn=10 rm=11 -> next cycle wr_en=1, wr_addr=0, wr_data=0x8B0B0149.
REQ-029 SHALL test: LDUR rd=1 rn=2 imm=8 then CBZ rd=3 imm=-2 in_last -> 0xF8408041 at addr 0, 0xB4FFFFC3 at addr 1, done=1, in_ready=0.
REQ-030 SHALL test: 70 back-to-back valid beats -> exactly 64 writes addr 0..63, done after 64th, no wrap.
REQ-031 SHALL test: op=7 between two ADDs -> err_illegal=1, ADDs written at addr 0 and 1.
REQ-032 SHALL test: LDUR imm=300 -> with macro err_range=1 and no write; without macro write of imm[8:0]=0x12C.
REQ-033 SHALL test: reset asserted mid-session with in_valid=1 -> all outputs 0 asynchronously; start after release resumes at addr 0.
